mdu_ctrl: RTL and testbench
===========================

// Module: mdu_ctrl
// PURPOSE
//  Execute-stage multiply/divide controller. It sequences a multi-cycle MULT/MULTU/DIV/DIVU,
//  owns the HI/LO registers and handles single-cycle MTHI/MTLO.
//  It drives busy/stall_md so the hazard stall logic freezes F/D while an MD-class instruction
//  in D would observe an in-flight operation.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (1..15)
//  DIV_CYCLES   10  busy cycles for DIV/DIVU (1..15)
// PORTS
//  clk       in   1   system clock, rising edge
//  reset_n   in   1   asynchronous, active-low reset
//  start     in   1   E-stage MD instruction valid this cycle (one-cycle pulse per instr)
//  op        in   4   MD_* opcode from const.v (MULT,MULTU,DIV,DIVU,MTHI,MTLO[,MADD..])
//  A         in   32  forwarded rs value
//  B         in   32  forwarded rt value
//  D_md      in   1   D-stage instr is MD class (mult/div/mfhi/mflo/mthi/mtlo)
//  busy      out  1   multi-cycle op in flight
//  stall_md  out  1   = D_md & (start_long | busy); OR'd into pipeline stall
//  hi        out  32  HI register
//  lo        out  32  LO register
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE, cnt=0, busy=0, hi=lo=0, pending results cleared.
//    A reset mid-operation aborts the op; HI/LO are not updated.
//  - FSM states: IDLE, BUSY.
//    IDLE & start & long op (MULT/MULTU/DIV/DIVU): latch the result into hi_nxt/lo_nxt,
//    load cnt=N (MULT_CYCLES or DIV_CYCLES) and go to BUSY.
//    BUSY: cnt decrements each cycle. When cnt==1, commit hi<=hi_nxt, lo<=lo_nxt and
//    return to IDLE (cnt=0).
//  - Latency: start in cycle t gives busy=1 in cycles t+1..t+N. New HI/LO are visible from
//    cycle t+N+1, which is the first cycle with busy=0.
//  - MTHI/MTLO in IDLE: hi<=A or lo<=A at the edge ending the start cycle; busy stays 0.
//  - start while BUSY: ignored (no state, HI/LO or cnt change). The stall logic guarantees
//    this cannot happen.
//  - Arithmetic:
//    MULT: {hi,lo} = $signed(A)*$signed(B), 64-bit.
//    MULTU: unsigned 64-bit product.
//    DIV: lo = quotient, hi = remainder; signed, truncate toward zero, remainder sign = A.
//    DIVU: unsigned quotient/remainder.
//  - B==0 on DIV/DIVU: the full N-cycle busy sequence still runs; hi/lo keep their old values.
//  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
//  - stall_md is combinational: D_md & ((start & op is long) | busy). mfhi/mflo in D stalls
//    in the start cycle and through every BUSY cycle.
//  - Undefined op with start: treated as no-op.
// CONFIGURATION
//  - MDU_MADD_EN defined: adds MADD/MADDU/MSUB/MSUBU. These use MULT_CYCLES and commit
//    {hi,lo} +/- product. The operand {hi,lo} is sampled at start.
//  - MDU_MADD_EN undefined: those opcodes are treated as no-op.
// STRUCTURE
//  - const.v (shared): MD_* op encodings (4-bit), MD state encodings IDLE/BUSY.
//  - Sub-module mdu_arith (combinational): op, A, B, hi, lo -> hi_nxt, lo_nxt, is_long.
//    It keeps the signed/unsigned/madd datapath out of the FSM.
//  - mdu_ctrl holds the FSM, 4-bit cnt, HI/LO and staging registers.
// TESTING
//  1. Reset, then MULT: A=0xFFFFFFFE(-2), B=3 -> busy high 5 cycles;
//     then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//  2. DIV: A=-7, B=2 -> busy high 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     DIVU: A=7, B=2 -> lo=3, hi=1.
//  3. MTHI A=0x12345678 in IDLE -> hi=0x12345678 next cycle, busy=0 throughout.
//     D_md=1 with start=0 and busy=0 -> stall_md=0.
//  4. MULT start with D_md=1 -> stall_md=1 in the start cycle and all 5 busy cycles,
//     0 in the first cycle after. The mflo issued then reads the new lo.
//  5. DIVU with B=0, hi=lo=0xAAAA0000 -> busy 10 cycles, hi/lo unchanged.
//     start during BUSY -> ignored.
//  6. Drop reset_n at cycle 3 of a DIV -> busy=0 and hi=lo=0 immediately (async).
//     With MDU_MADD_EN: hi=0, lo=1, MADD A=2, B=3 -> lo=7.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// Shared opcode/state encodings and small helpers for the multiply/divide unit.
// Optional MADD/MADDU/MSUB/MSUBU support is enabled by defining MDU_MADD_EN.
package mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        MD_NOP   = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8,
        MD_MSUB  = 4'd9,
        MD_MSUBU = 4'd10
    } md_op_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    localparam int unsigned MD_CNT_W = 4;

    // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    function automatic logic is_div_op(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Execute-stage <-> multiply/divide unit signal bundle.
// master = pipeline side, slave = mdu_ctrl.
interface mdu_ctrl_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        D_md;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, A, B, D_md,
        input  busy, stall_md, hi, lo
    );

    modport slave (
        input  start, op, A, B, D_md,
        output busy, stall_md, hi, lo
    );
endinterface

// File: rtl/mdu_arith.sv
// Combinational MD datapath: computes the HI/LO result of a long op and flags it as long.
// MDU_MADD_EN adds the accumulate/subtract forms on top of the {hi,lo} operand.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [31:0] hi_nxt_o,
    output logic [31:0] lo_nxt_o,
    output logic        is_long_o
);

    md_op_e      op_s;
    logic [63:0] prod_s_s;
    logic [63:0] prod_u_s;
    logic [31:0] ua_s;
    logic [31:0] ub_s;
    logic [31:0] sdiv_s;
    logic [31:0] udiv_s;
    logic [31:0] sq_mag_s;
    logic [31:0] sr_mag_s;
    logic [31:0] sq_s;
    logic [31:0] sr_s;
    logic [31:0] uq_s;
    logic [31:0] ur_s;

    assign op_s = md_op_e'(op_i);

    // Low 64 bits of the sign-extended product equal the signed 64-bit product.
    assign prod_s_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
    assign prod_u_s = {32'd0, a_i} * {32'd0, b_i};

    // Signed divide on magnitudes avoids the 0x80000000 / -1 overflow corner.
    assign ua_s     = mag32(a_i);
    assign ub_s     = mag32(b_i);
    assign sdiv_s   = (ub_s == 32'd0) ? 32'd1 : ub_s;
    assign udiv_s   = (b_i == 32'd0) ? 32'd1 : b_i;
    assign sq_mag_s = ua_s / sdiv_s;
    assign sr_mag_s = ua_s % sdiv_s;
    assign sq_s     = (a_i[31] ^ b_i[31]) ? (~sq_mag_s + 32'd1) : sq_mag_s;
    assign sr_s     = a_i[31] ? (~sr_mag_s + 32'd1) : sr_mag_s;
    assign uq_s     = a_i / udiv_s;
    assign ur_s     = a_i % udiv_s;

`ifdef MDU_MADD_EN
    logic [63:0] acc_s;
    assign acc_s = {hi_i, lo_i};
`endif

    // Result select; divide-by-zero and non-long ops leave HI/LO as they are.
    always_comb begin
        hi_nxt_o  = hi_i;
        lo_nxt_o  = lo_i;
        is_long_o = 1'b0;
        case (op_s)
            MD_MULT: begin
                {hi_nxt_o, lo_nxt_o} = prod_s_s;
                is_long_o            = 1'b1;
            end
            MD_MULTU: begin
                {hi_nxt_o, lo_nxt_o} = prod_u_s;
                is_long_o            = 1'b1;
            end
            MD_DIV: begin
                is_long_o = 1'b1;
                if (b_i != 32'd0) begin
                    lo_nxt_o = sq_s;
                    hi_nxt_o = sr_s;
                end else begin
                    lo_nxt_o = lo_i;
                    hi_nxt_o = hi_i;
                end
            end
            MD_DIVU: begin
                is_long_o = 1'b1;
                if (b_i != 32'd0) begin
                    lo_nxt_o = uq_s;
                    hi_nxt_o = ur_s;
                end else begin
                    lo_nxt_o = lo_i;
                    hi_nxt_o = hi_i;
                end
            end
`ifdef MDU_MADD_EN
            MD_MADD: begin
                {hi_nxt_o, lo_nxt_o} = acc_s + prod_s_s;
                is_long_o            = 1'b1;
            end
            MD_MADDU: begin
                {hi_nxt_o, lo_nxt_o} = acc_s + prod_u_s;
                is_long_o            = 1'b1;
            end
            MD_MSUB: begin
                {hi_nxt_o, lo_nxt_o} = acc_s - prod_s_s;
                is_long_o            = 1'b1;
            end
            MD_MSUBU: begin
                {hi_nxt_o, lo_nxt_o} = acc_s - prod_u_s;
                is_long_o            = 1'b1;
            end
`endif
            default: begin
                hi_nxt_o  = hi_i;
                lo_nxt_o  = lo_i;
                is_long_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: IDLE/BUSY sequencer, HI/LO ownership and the D-stage MD stall.
// Build option MDU_MADD_EN (handled in mdu_arith) enables the multiply-accumulate opcodes.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    mdu_ctrl_if.slave   md
);

    localparam logic [MD_CNT_W-1:0] MULT_N = MD_CNT_W'(MULT_CYCLES);
    localparam logic [MD_CNT_W-1:0] DIV_N  = MD_CNT_W'(DIV_CYCLES);

    md_state_e             state_q,  state_d;
    logic [MD_CNT_W-1:0]   cnt_q,    cnt_d;
    logic [31:0]           hi_q,     hi_d;
    logic [31:0]           lo_q,     lo_d;
    logic [31:0]           hi_stg_q, hi_stg_d;
    logic [31:0]           lo_stg_q, lo_stg_d;

    md_op_e                op_s;
    logic [31:0]           hi_nxt_s;
    logic [31:0]           lo_nxt_s;
    logic                  is_long_s;
    logic [MD_CNT_W-1:0]   n_load_s;
    logic                  busy_s;

    assign op_s     = md_op_e'(md.op);
    assign n_load_s = is_div_op(op_s) ? DIV_N : MULT_N;
    assign busy_s   = (state_q == MD_BUSY);

    mdu_arith u_arith (
        .op_i      (md.op),
        .a_i       (md.A),
        .b_i       (md.B),
        .hi_i      (hi_q),
        .lo_i      (lo_q),
        .hi_nxt_o  (hi_nxt_s),
        .lo_nxt_o  (lo_nxt_s),
        .is_long_o (is_long_s)
    );

    assign md.busy     = busy_s;
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;
    assign md.stall_md = md.D_md & ((md.start & is_long_s) | busy_s);

    // Next-state: accept ops only in IDLE, count down in BUSY and commit on the last cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_stg_d = hi_stg_q;
        lo_stg_d = lo_stg_q;
        case (state_q)
            MD_IDLE: begin
                if (md.start && is_long_s) begin
                    hi_stg_d = hi_nxt_s;
                    lo_stg_d = lo_nxt_s;
                    cnt_d    = n_load_s;
                    state_d  = MD_BUSY;
                end else if (md.start && (op_s == MD_MTHI)) begin
                    hi_d = md.A;
                end else if (md.start && (op_s == MD_MTLO)) begin
                    lo_d = md.A;
                end else begin
                    state_d = MD_IDLE;
                end
            end
            MD_BUSY: begin
                // <= also retires a stray zero count instead of wrapping to 15.
                if (cnt_q <= MD_CNT_W'(1)) begin
                    hi_d    = hi_stg_q;
                    lo_d    = lo_stg_q;
                    cnt_d   = '0;
                    state_d = MD_IDLE;
                end else begin
                    cnt_d = cnt_q - MD_CNT_W'(1);
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter, HI/LO and staging registers; reset aborts any op in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            hi_stg_q <= 32'd0;
            lo_stg_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_stg_q <= hi_stg_d;
            lo_stg_q <= lo_stg_d;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl with hand-computed HI/LO, busy and stall values.
// Define MDU_MADD_EN for both RTL and bench to exercise the multiply-accumulate path.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    mdu_ctrl_if md_if();

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .md      (md_if)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle start of a short (or no-op) instruction; busy must never rise.
    task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a);
        md_if.start = 1'b1;
        md_if.op    = op;
        md_if.A     = a;
        md_if.B     = 32'd3;
        #1;
        check_eq({tag, "_busy_start"}, {31'd0, md_if.busy}, 32'd0);
        check_eq({tag, "_stall_start"}, {31'd0, md_if.stall_md}, 32'd0);
        step();
        md_if.start = 1'b0;
        #1;
        check_eq({tag, "_busy_after"}, {31'd0, md_if.busy}, 32'd0);
    endtask

    // Long op: busy for exactly n cycles, stall tracks D_md; optional start injected at cycle inj_at.
    task automatic run_long(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input int n, input logic dmd, input int inj_at);
        md_if.start = 1'b1;
        md_if.op    = op;
        md_if.A     = a;
        md_if.B     = b;
        md_if.D_md  = dmd;
        #1;
        check_eq({tag, "_busy_start"}, {31'd0, md_if.busy}, 32'd0);
        check_eq({tag, "_stall_start"}, {31'd0, md_if.stall_md}, {31'd0, dmd});
        step();
        for (int i = 0; i < n; i++) begin
            if (i == inj_at) begin
                md_if.start = 1'b1;
                md_if.op    = MD_MTLO;
                md_if.A     = 32'h5555_5555;
            end else begin
                md_if.start = 1'b0;
            end
            #1;
            check_eq($sformatf("%s_busy_c%0d", tag, i + 1), {31'd0, md_if.busy}, 32'd1);
            check_eq($sformatf("%s_stall_c%0d", tag, i + 1), {31'd0, md_if.stall_md}, {31'd0, dmd});
            step();
        end
        md_if.start = 1'b0;
        #1;
        check_eq({tag, "_busy_end"}, {31'd0, md_if.busy}, 32'd0);
        check_eq({tag, "_stall_end"}, {31'd0, md_if.stall_md}, 32'd0);
        md_if.D_md = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        md_if.start = 1'b0;
        md_if.op    = 4'd0;
        md_if.A     = 32'd0;
        md_if.B     = 32'd0;
        md_if.D_md  = 1'b0;
        #12;
        check_eq("rst_busy", {31'd0, md_if.busy}, 32'd0);
        check_eq("rst_hi", md_if.hi, 32'd0);
        check_eq("rst_lo", md_if.lo, 32'd0);
        check_eq("rst_stall", {31'd0, md_if.stall_md}, 32'd0);
        step();
        reset_n = 1'b1;
        step();

        // Multiply, signed and unsigned
        run_long("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, 5, 1'b0, -1);
        check_eq("mult_hi", md_if.hi, 32'hFFFF_FFFF);
        check_eq("mult_lo", md_if.lo, 32'hFFFF_FFFA);
        run_long("multu", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b0, -1);
        check_eq("multu_hi", md_if.hi, 32'hFFFF_FFFE);
        check_eq("multu_lo", md_if.lo, 32'h0000_0001);

        // Divide: truncation toward zero, remainder takes sign of A, overflow corner
        run_long("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 1'b0, -1);
        check_eq("div_m7_2_lo", md_if.lo, 32'hFFFF_FFFD);
        check_eq("div_m7_2_hi", md_if.hi, 32'hFFFF_FFFF);
        run_long("div_7_m2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 10, 1'b0, -1);
        check_eq("div_7_m2_lo", md_if.lo, 32'hFFFF_FFFD);
        check_eq("div_7_m2_hi", md_if.hi, 32'h0000_0001);
        run_long("divu", MD_DIVU, 32'd7, 32'd2, 10, 1'b0, -1);
        check_eq("divu_lo", md_if.lo, 32'd3);
        check_eq("divu_hi", md_if.hi, 32'd1);
        run_long("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0, -1);
        check_eq("div_ovf_lo", md_if.lo, 32'h8000_0000);
        check_eq("div_ovf_hi", md_if.hi, 32'd0);

        // MTHI / MTLO and stall with no long op around
        issue("mthi", MD_MTHI, 32'h1234_5678);
        check_eq("mthi_hi", md_if.hi, 32'h1234_5678);
        check_eq("mthi_lo_kept", md_if.lo, 32'h8000_0000);
        md_if.D_md = 1'b1;
        #1;
        check_eq("dmd_idle_stall", {31'd0, md_if.stall_md}, 32'd0);
        issue("mtlo", MD_MTLO, 32'h0BAD_CAFE);
        md_if.D_md = 1'b0;
        check_eq("mtlo_lo", md_if.lo, 32'h0BAD_CAFE);
        check_eq("mtlo_hi_kept", md_if.hi, 32'h1234_5678);

        // MULT with MD instruction waiting in D: stall through start + busy, new LO after
        run_long("mult_stall", MD_MULT, 32'h0001_0000, 32'h0001_0000, 5, 1'b1, -1);
        check_eq("mult_stall_hi", md_if.hi, 32'd1);
        check_eq("mult_stall_lo", md_if.lo, 32'd0);

        // Divide by zero keeps HI/LO; a start during BUSY is ignored
        issue("set_hi", MD_MTHI, 32'hAAAA_0000);
        issue("set_lo", MD_MTLO, 32'hAAAA_0000);
        run_long("divu_z", MD_DIVU, 32'd1234, 32'd0, 10, 1'b0, 3);
        check_eq("divu_z_hi", md_if.hi, 32'hAAAA_0000);
        check_eq("divu_z_lo", md_if.lo, 32'hAAAA_0000);
        run_long("div_z", MD_DIV, 32'hFFFF_FF00, 32'd0, 10, 1'b0, -1);
        check_eq("div_z_hi", md_if.hi, 32'hAAAA_0000);
        check_eq("div_z_lo", md_if.lo, 32'hAAAA_0000);

        // Undefined opcode is a no-op
        issue("undef", 4'hF, 32'hDEAD_BEEF);
        check_eq("undef_hi", md_if.hi, 32'hAAAA_0000);
        check_eq("undef_lo", md_if.lo, 32'hAAAA_0000);

        // Multiply-accumulate, or no-op when the option is off
        issue("madd_hi0", MD_MTHI, 32'd0);
        issue("madd_lo1", MD_MTLO, 32'd1);
`ifdef MDU_MADD_EN
        run_long("madd", MD_MADD, 32'd2, 32'd3, 5, 1'b0, -1);
        check_eq("madd_hi", md_if.hi, 32'd0);
        check_eq("madd_lo", md_if.lo, 32'd7);
`else
        issue("madd_off", MD_MADD, 32'd2);
        check_eq("madd_off_hi", md_if.hi, 32'd0);
        check_eq("madd_off_lo", md_if.lo, 32'd1);
`endif

        // Asynchronous reset in the middle of a DIV
        md_if.start = 1'b1;
        md_if.op    = MD_DIV;
        md_if.A     = 32'd100;
        md_if.B     = 32'd7;
        step();
        md_if.start = 1'b0;
        step();
        step();
        check_eq("abort_busy_pre", {31'd0, md_if.busy}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("abort_busy", {31'd0, md_if.busy}, 32'd0);
        check_eq("abort_hi", md_if.hi, 32'd0);
        check_eq("abort_lo", md_if.lo, 32'd0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
        end
        check_eq("abort_busy_post", {31'd0, md_if.busy}, 32'd0);
        check_eq("abort_hi_post", md_if.hi, 32'd0);
        check_eq("abort_lo_post", md_if.lo, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
